cpu_bus_ctrl: RTL and testbench

Downstream of the Cpu core. Accepts the core's level-held read/write requests (req_rdwr, which_rdwr, addr, data_out) and runs each as a single access on a generic memory port with a req/ack handshake. Returns read data and a one-cycle completion strobe to the core. Sits between the Cpu and the board RAM/ROM wrapper, and isolates the core from variable memory latency.

---
 rtl/cpu_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cpu_bus_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_ctrl.sv
// CPU-side bus controller: turns the core's level-held request into one memory req/ack access.
// Optional access timeout is compiled in with CPU_BUS_CTRL_TIMEOUT_EN.
module cpu_bus_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MIN_WAIT       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cpu_req,
    input  logic                  cpu_which,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StRecover} state_e;

    localparam logic [3:0] MinWait = 4'(MIN_WAIT);

    if (MIN_WAIT > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cpu_bus_ctrl: MIN_WAIT must be 0..15 and TIMEOUT_CYCLES at least 1");
    end

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  ack_ok;

`ifdef CPU_BUS_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            cpu_err_q, cpu_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
`ifdef CPU_BUS_CTRL_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            cpu_err_q   <= 1'b0;
`endif
        end else if (enable) begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
`ifdef CPU_BUS_CTRL_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            cpu_err_q   <= cpu_err_d;
`endif
        end
    end

    // Ack counts only once mem_req has been up for MIN_WAIT cycles.
    assign ack_ok = mem_ack && (wait_cnt_q >= MinWait);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
`ifdef CPU_BUS_CTRL_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        cpu_err_d   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    mem_we_d    = cpu_which;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_req_d   = 1'b1;
                    wait_cnt_d  = '0;
`ifdef CPU_BUS_CTRL_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (wait_cnt_q != 4'd15) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
                if (ack_ok) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                    cpu_ack_d = 1'b1;
                    state_d   = StDone;
`ifdef CPU_BUS_CTRL_TIMEOUT_EN
                end else if (tmo_cnt_q == TmoLast) begin
                    // Abort with open-bus data so the core never stalls forever.
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = '1;
                    cpu_ack_d   = 1'b1;
                    cpu_err_d   = 1'b1;
                    state_d     = StDone;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                state_d = StRecover;
            end
            StRecover: begin
                // Dead cycle lets the core's registered request drop after cpu_ack.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef CPU_BUS_CTRL_TIMEOUT_EN
    assign cpu_err   = cpu_err_q;
`else
    assign cpu_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl with MIN_WAIT = 1.
// Timeout scenario follows CPU_BUS_CTRL_TIMEOUT_EN (TIMEOUT_CYCLES = 8 when defined).
module tb_cpu_bus_ctrl;

`ifdef CPU_BUS_CTRL_TIMEOUT_EN
    localparam int unsigned TmoCycles = 8;
`else
    localparam int unsigned TmoCycles = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cpu_req;
    logic        cpu_which;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    cpu_bus_ctrl #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (8),
        .MIN_WAIT      (1),
        .TIMEOUT_CYCLES(TmoCycles)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cpu_req  (cpu_req),
        .cpu_which(cpu_which),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .cpu_err  (cpu_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "bench time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, cpu_ack, cpu_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {mem_req, mem_we, cpu_ack, cpu_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, cpu_rdata});
        end
        // Start an access, then reset while mem_req is up.
        rst       = 1'b0;
        cpu_req   = 1'b1;
        cpu_which = 1'b1;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h99;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h1234) begin
            errors++;
            $display("FAIL reset_pre_access got req=%b addr=%h want req=1 addr=1234",
                     mem_req, mem_addr);
        end
        cpu_req = 1'b0;
        rst     = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 26'h0) begin
            errors++;
            $display("FAIL reset_mid_access got req=%b we=%b addr=%h wdata=%h want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        rst     = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_stray_ack got ack=%b req=%b want 0 0", cpu_ack, mem_req);
        end
    endtask

    task automatic test_read;
        cpu_req   = 1'b1;
        cpu_which = 1'b0;
        cpu_addr  = 16'h2329;
        cpu_wdata = 8'h00;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h2329) begin
            errors++;
            $display("FAIL read_issue got req=%b we=%b addr=%h want 1 0 2329",
                     mem_req, mem_we, mem_addr);
        end
        // Early ack must be ignored; later cpu_addr changes must not leak through.
        mem_ack   = 1'b1;
        mem_rdata = 8'hA5;
        cpu_addr  = 16'hFFFF;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h2329) begin
            errors++;
            $display("FAIL read_early_ack got ack=%b req=%b addr=%h want 0 1 2329",
                     cpu_ack, mem_req, mem_addr);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL read_complete got ack=%b rdata=%h req=%b want 1 a5 0",
                     cpu_ack, cpu_rdata, mem_req);
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL read_ack_pulse got ack=%b rdata=%h want 0 a5", cpu_ack, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_write;
        int acks;
        cpu_req   = 1'b1;
        cpu_which = 1'b1;
        cpu_addr  = 16'h9001;
        cpu_wdata = 8'h3C;
        mem_ack   = 1'b1;
        mem_rdata = 8'h11;
        tick();
        cpu_wdata = 8'hFF;
        cpu_which = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'h3C || mem_addr !== 16'h9001)
        begin
            errors++;
            $display("FAIL write_issue got req=%b we=%b wdata=%h addr=%h want 1 1 3c 9001",
                     mem_req, mem_we, mem_wdata, mem_addr);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL write_hold got ack=%b we=%b wdata=%h want 0 1 3c",
                     cpu_ack, mem_we, mem_wdata);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL write_complete got ack=%b rdata=%h req=%b want 1 a5 0",
                     cpu_ack, cpu_rdata, mem_req);
        end
        cpu_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ack === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL write_single_ack got extra_acks=%0d req=%b want 0 0", acks, mem_req);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        int ack1, ack2, req1, req2, n_ack, n_req;
        logic prev_req;
        ack1 = -1; ack2 = -1; req1 = -1; req2 = -1;
        n_ack = 0; n_req = 0;
        prev_req  = mem_req;
        cpu_req   = 1'b1;
        cpu_which = 1'b0;
        cpu_addr  = 16'h0100;
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                n_req++;
                if (req1 < 0) req1 = i; else if (req2 < 0) req2 = i;
            end
            if (cpu_ack === 1'b1) begin
                n_ack++;
                if (ack1 < 0) ack1 = i;
                else if (ack2 < 0) begin
                    ack2    = i;
                    cpu_req = 1'b0;
                end
            end
            prev_req = mem_req;
        end
        mem_ack = 1'b0;
        checks++;
        if (req1 !== 1 || ack1 !== 3) begin
            errors++;
            $display("FAIL b2b_first got req_edge=%0d ack_edge=%0d want 1 3", req1, ack1);
        end
        checks++;
        if (req2 !== 6) begin
            errors++;
            $display("FAIL b2b_second_req got edge=%0d want 6", req2);
        end
        checks++;
        if (ack2 - ack1 !== 5) begin
            errors++;
            $display("FAIL b2b_ack_spacing got %0d want 5", ack2 - ack1);
        end
        checks++;
        if (n_ack !== 2 || n_req !== 2) begin
            errors++;
            $display("FAIL b2b_counts got acks=%0d reqs=%0d want 2 2", n_ack, n_req);
        end
    endtask

    task automatic test_enable;
        cpu_req   = 1'b1;
        cpu_which = 1'b0;
        cpu_addr  = 16'h0042;
        mem_ack   = 1'b0;
        tick();
        cpu_req = 1'b0;
        tick();
        enable    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cpu_ack !== 1'b0 || mem_req !== 1'b1 || cpu_rdata !== 8'h5A) begin
                errors++;
                $display("FAIL enable_hold_%0d got ack=%b req=%b rdata=%h want 0 1 5a",
                         i, cpu_ack, mem_req, cpu_rdata);
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h77 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL enable_resume got ack=%b rdata=%h req=%b want 1 77 0",
                     cpu_ack, cpu_rdata, mem_req);
        end
        mem_ack = 1'b0;
        enable  = 1'b0;
        tick();
        tick();
        checks++;
        if (cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL enable_hold_ack got %b want 1", cpu_ack);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL enable_ack_clear got %b want 0", cpu_ack);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout;
        cpu_req   = 1'b1;
        cpu_which = 1'b0;
        cpu_addr  = 16'h0300;
        mem_ack   = 1'b0;
        tick();
        cpu_req = 1'b0;
`ifdef CPU_BUS_CTRL_TIMEOUT_EN
        begin
            int   ack_at;
            logic err_s, req_s;
            logic [7:0] rdata_s;
            ack_at = -1; err_s = 1'b0; req_s = 1'b1; rdata_s = 8'h00;
            for (int i = 1; i <= 20 && ack_at < 0; i++) begin
                tick();
                if (cpu_ack === 1'b1) begin
                    ack_at  = i;
                    err_s   = cpu_err;
                    req_s   = mem_req;
                    rdata_s = cpu_rdata;
                end
            end
            checks++;
            if (ack_at !== 8) begin
                errors++;
                $display("FAIL timeout_edge got %0d want 8", ack_at);
            end
            checks++;
            if (err_s !== 1'b1 || rdata_s !== 8'hFF || req_s !== 1'b0) begin
                errors++;
                $display("FAIL timeout_abort got err=%b rdata=%h req=%b want 1 ff 0",
                         err_s, rdata_s, req_s);
            end
            tick();
            checks++;
            if (cpu_err !== 1'b0 || cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL timeout_pulse got err=%b ack=%b want 0 0", cpu_err, cpu_ack);
            end
        end
`else
        begin
            int n_ack, n_err;
            n_ack = 0; n_err = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (cpu_ack === 1'b1) n_ack++;
                if (cpu_err !== 1'b0) n_err++;
            end
            checks++;
            if (n_ack !== 0 || n_err !== 0 || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL no_timeout got acks=%0d errs=%0d req=%b want 0 0 1",
                         n_ack, n_err, mem_req);
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout_reset got req=%b want 0", mem_req);
            end
        end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        cpu_req   = 1'b0;
        cpu_which = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_enable();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
